// File: rtl/relu_pkg.sv
// Shared constants and the forward-pass mask rule for the ReLU activation datapath.
// The mask bit is the same one the forward core uses to decide pass/zero.
package relu_pkg;

  localparam int DATA_W   = 32;
  localparam int SIGN_BIT = 31;
  localparam logic [DATA_W-1:0] ZERO_WORD = 32'h0;

  // Only the sign matters: -0.0 counts as negative, +0.0 as non-negative.
  function automatic logic mask_bit(input logic [DATA_W-1:0] value);
    return ~value[SIGN_BIT];
  endfunction

endpackage

// File: rtl/relu_mask_fifo.sv
// One-bit-wide synchronous FIFO holding forward-pass ReLU masks, with a
// synchronous flush that discards any push or pop in the same cycle.
module relu_mask_fifo
  import relu_pkg::*;
#(
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     wr_bit,
  input  logic                     pop,
  output logic                     rd_bit,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_en, pop_en;
  logic          mask_mem_q [DEPTH];

  always_comb begin
    push_en  = push && (count_q != FULL_CNT) && !clr;
    pop_en   = pop && (count_q != '0) && !clr;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_en)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_en, pop_en})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push_en) mask_mem_q[wr_ptr_q] <= wr_bit;
  end

  assign rd_bit = mask_mem_q[rd_ptr_q];
  assign count  = count_q;

endmodule

// File: rtl/relu_backward.sv
// ReLU backward pass: records forward masks, then zeroes gradients whose forward
// input was negative. Define RELU_BWD_STATUS_EN to add Mask_Count/Underrun_Err.
module relu_backward
  import relu_pkg::*;
#(
  parameter int DATA_W     = relu_pkg::DATA_W,
  parameter int MASK_DEPTH = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        Clr,
  input  logic [DATA_W-1:0]           Fwd_Data_In,
  input  logic                        Fwd_Valid_In,
  output logic                        Fwd_Ready_Out,
  input  logic [DATA_W-1:0]           Grad_In,
  input  logic                        Grad_Valid_In,
  output logic                        Grad_Ready_Out,
  output logic [DATA_W-1:0]           Grad_Out,
  output logic                        Grad_Valid_Out,
  input  logic                        Grad_Ready_In
`ifdef RELU_BWD_STATUS_EN
  ,
  output logic [$clog2(MASK_DEPTH):0] Mask_Count,
  output logic                        Underrun_Err
`endif
);

  localparam int CW = $clog2(MASK_DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(MASK_DEPTH);

  logic [CW-1:0]     mask_count;
  logic              rd_mask;
  logic              push, pop, pop_fire;
  logic [DATA_W-1:0] grad_out_q, grad_out_d;
  logic              grad_valid_q, grad_valid_d;

  // Readiness comes only from registered occupancy, never from same-cycle traffic.
  assign Fwd_Ready_Out  = (mask_count != FULL_CNT);
  assign Grad_Ready_Out = (mask_count != '0) && (!grad_valid_q || Grad_Ready_In);
  assign push           = Fwd_Valid_In && Fwd_Ready_Out;
  assign pop            = Grad_Valid_In && Grad_Ready_Out;
  assign pop_fire       = pop && !Clr;

  relu_mask_fifo #(
    .DEPTH (MASK_DEPTH)
  ) u_mask_fifo (
    .clk    (clk),
    .rst    (rst),
    .clr    (Clr),
    .push   (push),
    .wr_bit (mask_bit(Fwd_Data_In)),
    .pop    (pop),
    .rd_bit (rd_mask),
    .count  (mask_count)
  );

  always_comb begin
    grad_out_d   = grad_out_q;
    grad_valid_d = grad_valid_q;
    if (pop_fire) begin
      grad_out_d   = rd_mask ? Grad_In : ZERO_WORD;
      grad_valid_d = 1'b1;
    end else if (Grad_Ready_In) begin
      grad_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      grad_out_q   <= '0;
      grad_valid_q <= 1'b0;
    end else begin
      grad_out_q   <= grad_out_d;
      grad_valid_q <= grad_valid_d;
    end
  end

  assign Grad_Out       = grad_out_q;
  assign Grad_Valid_Out = grad_valid_q;

`ifdef RELU_BWD_STATUS_EN
  logic underrun_q, underrun_d;

  // Flush wins over a same-cycle underrun so a batch boundary always starts clean.
  always_comb begin
    underrun_d = underrun_q;
    if (Clr) begin
      underrun_d = 1'b0;
    end else if (Grad_Valid_In && (mask_count == '0) && !grad_valid_q) begin
      underrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) underrun_q <= 1'b0;
    else      underrun_q <= underrun_d;
  end

  assign Mask_Count   = mask_count;
  assign Underrun_Err = underrun_q;
`endif

endmodule
